// File: rtl/abs_sq_pkg.sv
// Shared types and width helpers for the sequential |sum(x*s)|^2 power stage.
package abs_sq_pkg;

  typedef enum logic [1:0] {IDLE, ACC, SQ, OUT} state_t;

  // Sum of N_CH complex products, each up to 2W+1 bits signed, without overflow.
  function automatic int acc_w(int w, int n_ch);
    return 2 * w + 1 + $clog2(n_ch);
  endfunction

  function automatic int out_w(int w, int n_ch);
    return 2 * acc_w(w, n_ch);
  endfunction

  function automatic longint NEG_FULL_SCALE(int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/cmul_stage.sv
// Combinational complex multiply of one channel; ABS_SQ_CMUL_CONJ_EN conjugates s.
module cmul_stage #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] xi,
  input  logic signed [W-1:0] xq,
  input  logic signed [W-1:0] si,
  input  logic signed [W-1:0] sq,
  output logic signed [2*W:0] p_i,
  output logic signed [2*W:0] p_q
);

  localparam int MW = 2 * W;
  localparam int PW = 2 * W + 1;

  logic signed [MW-1:0] xisi, xqsq, xisq, xqsi;

  assign xisi = MW'(xi) * MW'(si);
  assign xqsq = MW'(xq) * MW'(sq);
  assign xisq = MW'(xi) * MW'(sq);
  assign xqsi = MW'(xq) * MW'(si);

`ifdef ABS_SQ_CMUL_CONJ_EN
  assign p_i = PW'(xisi) + PW'(xqsq);
  assign p_q = PW'(xqsi) - PW'(xisq);
`else
  assign p_i = PW'(xisi) - PW'(xqsq);
  assign p_q = PW'(xisq) + PW'(xqsi);
`endif

endmodule

// File: rtl/abs_sq_cmul_seq.sv
// Time-multiplexed beamformer power |sum_k x_k*s_k|^2 with valid/ready framing.
// Build option: ABS_SQ_CMUL_CONJ_EN (conjugated steering, inside cmul_stage).
module abs_sq_cmul_seq
  import abs_sq_pkg::*;
#(
  parameter int W     = 16,
  parameter int N_CH  = 4,
  parameter int ACC_W = acc_w(W, N_CH),
  parameter int OUT_W = out_w(W, N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_CH*W-1:0]   x_i_vec,
  input  logic [N_CH*W-1:0]   x_q_vec,
  input  logic [N_CH*W-1:0]   s_i_vec,
  input  logic [N_CH*W-1:0]   s_q_vec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    result
);

  localparam int IDX_W = $clog2(N_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
  localparam int PW = 2 * W + 1;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [N_CH*W-1:0]         xi_r, xq_r, si_r, sq_r;
  logic signed [ACC_W-1:0]   i_acc, q_acc;
  logic signed [W-1:0]       xi_k, xq_k, si_k, sq_k;
  logic signed [PW-1:0]      p_i, p_q;
  logic signed [OUT_W-1:0]   i_ext, q_ext;
  logic [OUT_W-1:0]          sq_sum;

  assign xi_k = xi_r[idx*W +: W];
  assign xq_k = xq_r[idx*W +: W];
  assign si_k = si_r[idx*W +: W];
  assign sq_k = sq_r[idx*W +: W];

  cmul_stage #(.W(W)) u_cmul (
    .xi  (xi_k),
    .xq  (xq_k),
    .si  (si_k),
    .sq  (sq_k),
    .p_i (p_i),
    .p_q (p_q)
  );

  // Squares formed at full output width so the sum is exact for any accumulator value.
  assign i_ext  = OUT_W'(i_acc);
  assign q_ext  = OUT_W'(q_acc);
  assign sq_sum = $unsigned(i_ext * i_ext) + $unsigned(q_ext * q_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      i_acc     <= '0;
      q_acc     <= '0;
      xi_r      <= '0;
      xq_r      <= '0;
      si_r      <= '0;
      sq_r      <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xi_r     <= x_i_vec;
            xq_r     <= x_q_vec;
            si_r     <= s_i_vec;
            sq_r     <= s_q_vec;
            i_acc    <= '0;
            q_acc    <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ACC;
          end
        end
        ACC: begin
          i_acc <= i_acc + ACC_W'(p_i);
          q_acc <= q_acc + ACC_W'(p_q);
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) state <= SQ;
        end
        SQ: begin
          result    <= sq_sum;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abs_sq_cmul_seq.sv
// Scoreboard bench for abs_sq_cmul_seq (W=16, N_CH=4); expectations follow ABS_SQ_CMUL_CONJ_EN.
module tb_abs_sq_cmul_seq;
  import abs_sq_pkg::*;

  localparam int W     = 16;
  localparam int N_CH  = 4;
  localparam int OUT_W = 70;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [N_CH*W-1:0]  x_i_vec = '0, x_q_vec = '0, s_i_vec = '0, s_q_vec = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [OUT_W-1:0]   result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic prev_ov = 1'b0;
  logic [OUT_W-1:0] exp_q[$];
  int acc_q[$];

  abs_sq_cmul_seq #(.W(W), .N_CH(N_CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_i_vec   (x_i_vec),
    .x_q_vec   (x_q_vec),
    .s_i_vec   (s_i_vec),
    .s_q_vec   (s_q_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [N_CH*W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  // Monitor: latency from accept, result against scoreboard head while presented.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      cyc++;
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && !prev_ov && acc_q.size() > 0)
        chk("latency_edges", OUT_W'(cyc - acc_q.pop_front() - 1), OUT_W'(N_CH + 1));
      if (out_valid) begin
        chk("in_ready_while_out", OUT_W'(in_ready), '0);
        if (exp_q.size() == 0) begin
          chk("unexpected_output", OUT_W'(exp_q.size()), OUT_W'(1));
        end else begin
          chk("result", result, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic send_frame(input logic [N_CH*W-1:0] xi, input logic [N_CH*W-1:0] xq,
                            input logic [N_CH*W-1:0] si, input logic [N_CH*W-1:0] sq,
                            input logic [OUT_W-1:0] expv);
    bit accepted;
    accepted = 1'b0;
    @(posedge clk); #2;
    x_i_vec = xi; x_q_vec = xq; s_i_vec = si; s_q_vec = sq;
    in_valid = 1'b1;
    exp_q.push_back(expv);
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
    end
    if (!accepted) chk("accept_timeout", OUT_W'(accepted), OUT_W'(1));
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain_pending", OUT_W'(exp_q.size()), '0);
  endtask

  initial begin
    logic [OUT_W-1:0] fs_exp;
    logic [OUT_W-1:0] mix_exp;
    int fs;
    fs = int'(NEG_FULL_SCALE(W));
    fs_exp = OUT_W'(1) << 66;
`ifdef ABS_SQ_CMUL_CONJ_EN
    mix_exp = OUT_W'(306);
`else
    mix_exp = OUT_W'(522);
`endif

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", OUT_W'(in_ready), OUT_W'(1));
    chk("reset_out_valid", OUT_W'(out_valid), '0);
    chk("reset_result", result, '0);

    // Unit frame: each channel contributes 1, I=4.
    send_frame(pack4(1,1,1,1), pack4(0,0,0,0), pack4(1,1,1,1), pack4(0,0,0,0), OUT_W'(16));
    // (3+4j)(1+2j) = -5+10j; conjugated 11-2j; both give 125.
    send_frame(pack4(0,3,0,0), pack4(0,4,0,0), pack4(0,1,0,0), pack4(0,2,0,0), OUT_W'(125));
    send_frame(pack4(fs,fs,fs,fs), pack4(fs,fs,fs,fs), pack4(fs,fs,fs,fs), pack4(fs,fs,fs,fs), fs_exp);
    // ch0 (2-1j)(3+1j), ch3 (-5+7j)(0-2j): sum 21+9j; conjugated -9-15j.
    send_frame(pack4(2,0,0,-5), pack4(-1,0,0,7), pack4(3,0,0,0), pack4(1,0,0,-2), mix_exp);
    send_frame(pack4(0,0,-1,0), pack4(0,0,-1,0), pack4(0,0,-1,0), pack4(0,0,1,0), OUT_W'(4));
    send_frame(pack4(1,1,1,1), pack4(1,1,1,1), pack4(1,1,1,1), pack4(-1,-1,-1,-1), OUT_W'(64));
    drain();

    // Backpressure: hold frame A in OUT, frame B waits on the inputs.
    out_ready = 1'b0;
    send_frame(pack4(0,3,0,0), pack4(0,4,0,0), pack4(0,1,0,0), pack4(0,2,0,0), OUT_W'(125));
    x_i_vec = pack4(1,1,1,1); x_q_vec = '0; s_i_vec = pack4(1,1,1,1); s_q_vec = '0;
    in_valid = 1'b1;
    exp_q.push_back(OUT_W'(16));
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      chk("bp_in_ready_low", OUT_W'(in_ready), '0);
    end
    chk("bp_out_valid_held", OUT_W'(out_valid), OUT_W'(1));
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_accept", OUT_W'(in_ready), OUT_W'(1));
    @(posedge clk); #2;
    in_valid = 1'b0;
    drain();

    // Reset during ACC with idx=2, after a full-scale frame has loaded the accumulators.
    send_frame(pack4(fs,fs,fs,fs), pack4(fs,fs,fs,fs), pack4(fs,fs,fs,fs), pack4(fs,fs,fs,fs), fs_exp);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", OUT_W'(out_valid), '0);
    chk("midrst_result", result, '0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", OUT_W'(in_ready), OUT_W'(1));
    send_frame(pack4(0,0,-1,0), pack4(0,0,-1,0), pack4(0,0,-1,0), pack4(0,0,1,0), OUT_W'(4));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
